// File: rtl/ack_fanin_join_pkg.sv
// Shared types and defaults for the broadcast fan-in join and its sticky ack capture.
package ack_fanin_join_pkg;

  localparam int DEF_NUM_LEGS  = 3;
  localparam int MAX_LEGS      = 8;
  localparam int DEF_TIMEOUT_W = 8;
  localparam int DEF_TIMEOUT   = 200;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } join_state_e;

  typedef logic [DEF_NUM_LEGS-1:0] leg_vec_t;

  // Wait limit must fit the counter and allow at least one WAIT cycle.
  function automatic bit timeout_cfg_ok(input int timeout, input int width);
    return (timeout >= 1) && (timeout < (1 << width));
  endfunction

  function automatic bit legs_cfg_ok(input int legs);
    return (legs >= 1) && (legs <= MAX_LEGS);
  endfunction

endpackage

// File: rtl/ack_fanin_join_sticky.sv
// Per-leg sticky acknowledge capture with an all-enabled-legs-acked reduction
// evaluated on the next-state value, so a final ack completes in its own cycle.
module ack_sticky_vec #(
  parameter int N = 3
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [N-1:0] mask_i,
  input  logic [N-1:0] ack_i,
  output logic [N-1:0] ack_o,
  output logic [N-1:0] ack_next_o,
  output logic         all_acked_o
);

  logic [N-1:0] ack_q;
  logic [N-1:0] ack_d;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_leg
      // Acks are only meaningful while enabled and only for legs in the mask.
      assign ack_d[gi] = ack_q[gi] | (en_i & mask_i[gi] & ack_i[gi]);

      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          ack_q[gi] <= 1'b0;
        end else if (clr_i) begin
          ack_q[gi] <= 1'b0;
        end else begin
          ack_q[gi] <= ack_d[gi];
        end
      end
    end
  endgenerate

  assign ack_o       = ack_q;
  assign ack_next_o  = ack_d;
  assign all_acked_o = ((ack_d & mask_i) == mask_i);

endmodule

// File: rtl/ack_fanin_join.sv
// Broadcast fan-in join: issues per-leg requests, collects sticky acks and returns
// a single done pulse, or a timeout pulse with the list of silent legs.
module ack_fanin_join
  import ack_fanin_join_pkg::*;
#(
  parameter int NUM_LEGS  = DEF_NUM_LEGS,
  parameter int TIMEOUT_W = DEF_TIMEOUT_W,
  parameter int TIMEOUT   = DEF_TIMEOUT
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [NUM_LEGS-1:0] leg_mask,
  output logic [NUM_LEGS-1:0] leg_req,
  input  logic [NUM_LEGS-1:0] leg_ack,
  output logic                done,
  output logic                timeout,
  output logic [NUM_LEGS-1:0] err_legs,
  output logic                busy
);

  generate
    if (!timeout_cfg_ok(TIMEOUT, TIMEOUT_W) || !legs_cfg_ok(NUM_LEGS)) begin : g_bad_cfg
      $error("ack_fanin_join: illegal NUM_LEGS/TIMEOUT/TIMEOUT_W combination");
    end
  endgenerate

  localparam logic [TIMEOUT_W-1:0] CNT_LAST = TIMEOUT_W'(TIMEOUT - 1);
  localparam logic [TIMEOUT_W-1:0] CNT_MAX  = '1;

  join_state_e         state_q, state_d;
  logic [NUM_LEGS-1:0] mask_q, mask_d;
  logic [NUM_LEGS-1:0] err_legs_q, err_legs_d;
  logic                err_q, err_d;
  logic [TIMEOUT_W-1:0] cnt_q, cnt_d;

  logic                accept;
  logic                in_wait;
  logic [NUM_LEGS-1:0] ack_q;
  logic [NUM_LEGS-1:0] ack_next;
  logic                all_acked;

  assign in_wait = (state_q == WAIT);

  ack_sticky_vec #(
    .N (NUM_LEGS)
  ) u_sticky (
    .clock       (clock),
    .reset_n     (reset_n),
    .clr_i       (accept),
    .en_i        (in_wait),
    .mask_i      (mask_q),
    .ack_i       (leg_ack),
    .ack_o       (ack_q),
    .ack_next_o  (ack_next),
    .all_acked_o (all_acked)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      mask_q     <= '0;
      err_legs_q <= '0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      mask_q     <= mask_d;
      err_legs_q <= err_legs_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    mask_d     = mask_q;
    err_legs_d = err_legs_q;
    err_d      = err_q;
    cnt_d      = cnt_q;
    accept     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          accept     = 1'b1;
          mask_d     = leg_mask;
          cnt_d      = '0;
          err_d      = 1'b0;
          err_legs_d = '0;
          // An empty mask has nothing to wait for.
          state_d    = (|leg_mask) ? WAIT : RESP;
        end
      end
      WAIT: begin
        // Completion is tested first so a last-cycle ack beats expiry.
        if (all_acked) begin
          state_d = RESP;
        end else if (cnt_q == CNT_LAST) begin
          state_d    = RESP;
          err_d      = 1'b1;
          err_legs_d = mask_q & ~ack_next;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + TIMEOUT_W'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign req_ready = (state_q == IDLE);
  assign leg_req   = in_wait ? (mask_q & ~ack_q) : '0;
  assign done      = (state_q == RESP) & ~err_q;
  assign timeout   = (state_q == RESP) & err_q;
  assign busy      = in_wait | (state_q == RESP);
  assign err_legs  = err_legs_q;

endmodule
